// File: rtl/suma_serie_nib.sv
// Nibble-serial W-bit adder: one 4-bit slice per cycle through sum4_v2.
// The carry is held in a register between slices, and the sum shifts in from the MSB end.

module sum4_v2 (
  output logic [3:0] S,
  output logic       c_out,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in
);
  logic [4:0] c;

  assign c[0] = c_in;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign S[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c_out = c[4];
endmodule

module suma_serie_nib #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] s,
  output logic                 c_out,
  output logic                 overflow
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [W-1:0]  a_sh_reg;
  logic [W-1:0]  b_sh_reg;
  logic [W-1:0]  s_reg;
  logic [CW-1:0] cnt_reg;
  logic          carry_reg;
  logic          a_msb_reg;
  logic          b_msb_reg;
  logic          c_out_reg;
  logic          ovf_reg;

  logic [3:0]    nib_s;
  logic          nib_c;

  sum4_v2 u_add (nib_s, nib_c, a_sh_reg[3:0], b_sh_reg[3:0], carry_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      s_reg     <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= c_in;
            a_msb_reg <= a[W-1];
            b_msb_reg <= b[W-1];
            s_reg     <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          s_reg     <= {nib_s, s_reg[W-1:4]};
          a_sh_reg  <= {4'b0000, a_sh_reg[W-1:4]};
          b_sh_reg  <= {4'b0000, b_sh_reg[W-1:4]};
          carry_reg <= nib_c;
          cnt_reg   <= cnt_reg + CW'(1);
          // Last slice: its S[3] is the result sign bit.
          if (cnt_reg == CNT_LAST) begin
            c_out_reg <= nib_c;
            ovf_reg   <= (a_msb_reg == b_msb_reg) && (nib_s[3] != a_msb_reg);
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign s        = s_reg;
  assign c_out    = c_out_reg;
  assign overflow = ovf_reg;
endmodule

// File: tb/tb_suma_serie_nib.sv
// Randomized bench for suma_serie_nib: an arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latency.

module tb_suma_serie_nib;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c_out;
  logic         overflow;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  suma_serie_nib #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .s(s), .c_out(c_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: phase 0 idle, 1..N busy, N+1 done; result from plain arithmetic.
  int           phase;
  logic [W-1:0] exp_s;
  logic         exp_c;
  logic         exp_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0;
      exp_s <= '0;
      exp_c <= 1'b0;
      exp_v <= 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b} + (W+1)'(c_in);
        phase <= 1;
        exp_s <= sum[W-1:0];
        exp_c <= sum[W];
        exp_v <= (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
    end else if (phase == N + 1) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(phase >= 1 && phase <= N));
      check("done", 32'(done), 32'(phase == N + 1));
      if (phase == 0 || phase == N + 1) begin
        check("s", 32'(s), 32'(exp_s));
        check("c_out", 32'(c_out), 32'(exp_c));
        check("overflow", 32'(overflow), 32'(exp_v));
      end else begin
        check("c_out_run", 32'(c_out), 32'd0);
        check("overflow_run", 32'(overflow), 32'd0);
      end
    end
  end

  task automatic wait_done(inout int k);
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic [W-1:0] es, input logic ec, input logic ev);
    int k;
    @(negedge clk);
    a = ta; b = tb_v; c_in = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    wait_done(k);
    $display("op a=%04h b=%04h c_in=%0d -> s=%04h c_out=%0d ovf=%0d after %0d edges",
             ta, tb_v, tc, s, c_out, overflow, k);
    check("latency", 32'(k), 32'd5);
    check("lit_s", 32'(s), 32'(es));
    check("lit_c_out", 32'(c_out), 32'(ec));
    check("lit_overflow", 32'(overflow), 32'(ev));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Start held high; operand changes mid-run must not disturb the result.
    @(negedge clk);
    a = 16'h5555; b = 16'hAAAA; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a = 16'h1234;
    k = 2;
    wait_done(k);
    $display("held-start op -> s=%04h c_out=%0d after %0d edges", s, c_out, k);
    check("hs_latency", 32'(k), 32'd5);
    check("hs_s", 32'(s), 32'hFFFF);
    check("hs_c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    check("hs_gap_busy", 32'(busy), 32'd0);
    check("hs_gap_done", 32'(done), 32'd0);
    @(negedge clk);
    check("hs_reaccept_busy", 32'(busy), 32'd1);
    start = 1'b0;
    k = 1;
    wait_done(k);
    $display("re-accepted op -> s=%04h c_out=%0d", s, c_out);
    check("hs2_s", 32'(s), 32'hBCDE);
    check("hs2_c_out", 32'(c_out), 32'd0);

    // Asynchronous reset in the second RUN cycle.
    @(negedge clk);
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("mid-run reset: busy=%0d done=%0d s=%04h c_out=%0d ovf=%0d", busy, done, s, c_out, overflow);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    check("ar_s", 32'(s), 32'd0);
    check("ar_c_out", 32'(c_out), 32'd0);
    check("ar_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ar_no_done", 32'(done), 32'd0);
    end
    run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Randomized traffic; the model and compare process do the checking.
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = pick_operand(); b = pick_operand(); c_in = 1'($urandom);
      start = 1'b1;
      for (int h = 0, hold = $urandom_range(1, 8); h < hold; h++) begin
        @(negedge clk);
        if ($urandom_range(0, 2) == 0) begin
          a = pick_operand(); b = pick_operand(); c_in = 1'($urandom);
        end
      end
      start = 1'b0;
      k = 0;
      while (phase != 0 && k < 20) begin
        @(negedge clk);
        k++;
      end
      $display("random op %0d: last s=%04h c_out=%0d ovf=%0d expected s=%04h c_out=%0d ovf=%0d",
               t, s, c_out, overflow, exp_s, exp_c, exp_v);
      if (k >= 20) check("rand_timeout", 32'(phase), 32'd0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
